// File: rtl/writeback_rf.sv
// Writeback stage with integrated register file and Z/N flags.
// One instruction per two cycles: capture in IDLE, commit in COMMIT.
module writeback_rf #(
    parameter int DATA_W = 8,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W = 4,
    parameter int OP_W = 4,
    parameter logic [(2**OP_W)-1:0] WB_MASK = 'h007A,
    parameter int ZERO_REG0 = 0,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_val,
    input  logic              flush,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    output logic              done,
    output logic              flag_z,
    output logic              flag_n
);

    typedef enum logic {
        IDLE,
        COMMIT
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [ADDR_W-1:0]   h_addr;
    logic [DATA_W-1:0]   h_val;
    logic                pend_wr;
    logic                cap_wr;
    logic                byp_on;

    assign in_ready = (state == IDLE);

    // r0 writes are dropped at capture so the commit path needs no special case
    assign cap_wr = WB_MASK[in_op]
                  & ~((ZERO_REG0 != 0) && (in_addr == '0));

    assign byp_on = (BYPASS != 0) && (state == COMMIT)
                  && pend_wr && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            done    <= 1'b0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            h_addr  <= '0;
            h_val   <= '0;
            pend_wr <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        h_addr  <= in_addr;
                        h_val   <= in_val;
                        pend_wr <= cap_wr;
                        state   <= COMMIT;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (!flush) begin
                        done <= 1'b1;
                        if (pend_wr) begin
                            regs[h_addr] <= h_val;
                            flag_z       <= (h_val == '0);
                            flag_n       <= h_val[DATA_W-1];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ra_data = regs[ra_addr];
        if (byp_on && (ra_addr == h_addr)) begin
            ra_data = h_val;
        end
        if ((ZERO_REG0 != 0) && (ra_addr == '0)) begin
            ra_data = '0;
        end
    end

    always_comb begin
        rb_data = regs[rb_addr];
        if (byp_on && (rb_addr == h_addr)) begin
            rb_data = h_val;
        end
        if ((ZERO_REG0 != 0) && (rb_addr == '0)) begin
            rb_data = '0;
        end
    end

endmodule

// File: tb/tb_writeback_rf.sv
// Scoreboard bench for writeback_rf: default instance with random traffic,
// plus a 16-bit/32-entry ZERO_REG0 instance for directed corner cases.
module tb_writeback_rf;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [3:0] in_addr;
    logic [7:0] in_val;
    logic       flush;
    logic [3:0] ra_addr;
    logic [7:0] ra_data;
    logic [3:0] rb_addr;
    logic [7:0] rb_data;
    logic       done;
    logic       flag_z;
    logic       flag_n;

    logic        rst1_n;
    logic        v1;
    logic        rdy1;
    logic [3:0]  op1;
    logic [4:0]  addr1;
    logic [15:0] val1;
    logic        fl1;
    logic [4:0]  ra1;
    logic [15:0] rad1;
    logic [4:0]  rb1;
    logic [15:0] rbd1;
    logic        done1;
    logic        z1;
    logic        n1;

    int total = 0;
    int bad = 0;

    localparam logic [15:0] MASK = 16'h007A;

    typedef struct {
        logic z;
        logic n;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mdl [16];
    logic       mz;
    logic       mn;

    writeback_rf u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_addr(in_addr), .in_val(in_val),
        .flush(flush),
        .ra_addr(ra_addr), .ra_data(ra_data),
        .rb_addr(rb_addr), .rb_data(rb_data),
        .done(done), .flag_z(flag_z), .flag_n(flag_n)
    );

    writeback_rf #(
        .DATA_W(16), .NUM_REGS(32), .ADDR_W(5), .OP_W(4),
        .WB_MASK(16'h007A), .ZERO_REG0(1), .BYPASS(1)
    ) u_wide (
        .clk(clk), .rst_n(rst1_n),
        .in_valid(v1), .in_ready(rdy1),
        .in_op(op1), .in_addr(addr1), .in_val(val1),
        .flush(fl1),
        .ra_addr(ra1), .ra_data(rad1),
        .rb_addr(rb1), .rb_data(rbd1),
        .done(done1), .flag_z(z1), .flag_n(n1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected retirement
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done act=1 exp=0 t=%0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("flag_z", {31'd0, flag_z}, {31'd0, e.z});
                chk("flag_n", {31'd0, flag_n}, {31'd0, e.n});
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [3:0] addr,
                         input logic [7:0] val, input logic fl,
                         input logic hold);
        logic wr;
        exp_t e;
        chk("ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_op = op;
        in_addr = addr;
        in_val = val;
        @(posedge clk);
        #1;
        in_valid = hold;
        in_op = ~op;
        in_addr = addr + 4'd1;
        in_val = ~val;
        flush = fl;
        rb_addr = addr;
        #1;
        chk("ready_commit", {31'd0, in_ready}, 32'd0);
        chk("done_commit", {31'd0, done}, 32'd0);
        wr = MASK[op];
        chk("bypass", {24'd0, rb_data},
            {24'd0, (wr && !fl) ? val : mdl[addr]});
        if (!fl) begin
            if (wr) begin
                mdl[addr] = val;
                mz = (val == 8'd0);
                mn = val[7];
            end
            e.z = mz;
            e.n = mn;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic rd_chk(input logic [3:0] a, input logic [3:0] b);
        ra_addr = a;
        rb_addr = b;
        #1;
        chk("ra_data", {24'd0, ra_data}, {24'd0, mdl[a]});
        chk("rb_data", {24'd0, rb_data}, {24'd0, mdl[b]});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        rst1_n = 1'b0;
        in_valid = 1'b0;
        in_op = '0;
        in_addr = '0;
        in_val = '0;
        flush = 1'b0;
        ra_addr = '0;
        rb_addr = '0;
        v1 = 1'b0;
        op1 = '0;
        addr1 = '0;
        val1 = '0;
        fl1 = 1'b0;
        ra1 = '0;
        rb1 = '0;
        mz = 1'b0;
        mn = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rst1_n = 1'b1;
        #1;

        for (int i = 0; i < 16; i++) begin
            ra_addr = i[3:0];
            rb_addr = 4'(15 - i);
            #0.1;
            chk("rst_ra", {24'd0, ra_data}, 32'd0);
            chk("rst_rb", {24'd0, rb_data}, 32'd0);
        end
        chk("rst_z", {31'd0, flag_z}, 32'd0);
        chk("rst_n_flag", {31'd0, flag_n}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;

        issue(4'd5, 4'd3, 8'h80, 1'b0, 1'b0);
        rd_chk(4'd3, 4'd3);
        issue(4'd2, 4'd3, 8'h55, 1'b0, 1'b0);
        rd_chk(4'd3, 4'd0);
        issue(4'd3, 4'd7, 8'h11, 1'b0, 1'b0);
        issue(4'd3, 4'd7, 8'h00, 1'b1, 1'b0);
        rd_chk(4'd7, 4'd3);
        @(posedge clk);
        #1;
        chk("flush_no_done", {31'd0, done}, 32'd0);
        issue(4'd3, 4'd7, 8'h00, 1'b0, 1'b1);
        rd_chk(4'd7, 4'd7);

        // flush while idle must not capture anything
        in_valid = 1'b1;
        in_op = 4'd3;
        in_addr = 4'd9;
        in_val = 8'hAA;
        flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        chk("idle_flush_ready", {31'd0, in_ready}, 32'd1);
        rd_chk(4'd9, 4'd9);
        @(posedge clk);
        #1;

        for (int k = 0; k < 300; k++) begin
            logic [7:0] v;
            int sel;
            sel = $urandom_range(0, 3);
            v = 8'($urandom);
            if (sel == 0) v = 8'd0;
            if (sel == 1) v = v | 8'h80;
            issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), v,
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
            rd_chk(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);

        // wide instance: 16-bit data, 32 regs, r0 hardwired to zero
        v1 = 1'b1;
        op1 = 4'd4;
        addr1 = 5'd31;
        val1 = 16'hFFFF;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        chk("w_ready_commit", {31'd0, rdy1}, 32'd0);
        @(posedge clk);
        #1;
        chk("w_done", {31'd0, done1}, 32'd1);
        chk("w_flag_n", {31'd0, n1}, 32'd1);
        chk("w_flag_z", {31'd0, z1}, 32'd0);
        ra1 = 5'd31;
        rb1 = 5'd31;
        #1;
        chk("w_ra31", {16'd0, rad1}, 32'h0000FFFF);
        chk("w_rb31", {16'd0, rbd1}, 32'h0000FFFF);

        v1 = 1'b1;
        op1 = 4'd1;
        addr1 = 5'd0;
        val1 = 16'hFFFF;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        ra1 = 5'd0;
        rb1 = 5'd0;
        #1;
        chk("w_r0_byp", {16'd0, rad1}, 32'd0);
        @(posedge clk);
        #1;
        chk("w_r0_done", {31'd0, done1}, 32'd1);
        chk("w_r0_ra", {16'd0, rad1}, 32'd0);
        chk("w_r0_rb", {16'd0, rbd1}, 32'd0);
        chk("w_r0_n", {31'd0, n1}, 32'd1);
        chk("w_r0_z", {31'd0, z1}, 32'd0);

        v1 = 1'b1;
        op1 = 4'd4;
        addr1 = 5'd31;
        val1 = 16'h1234;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        rst1_n = 1'b0;
        #1;
        chk("w_rst_done", {31'd0, done1}, 32'd0);
        @(posedge clk);
        #1;
        rst1_n = 1'b1;
        ra1 = 5'd31;
        #1;
        chk("w_rst_r31", {16'd0, rad1}, 32'd0);
        chk("w_rst_ready", {31'd0, rdy1}, 32'd1);
        chk("w_rst_n", {31'd0, n1}, 32'd0);
        @(posedge clk);
        #1;
        chk("w_rst_nodone", {31'd0, done1}, 32'd0);
        chk("w_rst_r31b", {16'd0, rad1}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
